// File: rtl/tcb_lib_memory.sv
// rtl/tcb_lib_memory.sv - TCB subordinate RAM with byte enables and fixed DLY-cycle response.
// Optional out-of-range error reporting: define TCB_LIB_MEMORY_ERR_EN.
module tcb_lib_memory #(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned SIZ = 4096,
  parameter int unsigned DLY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tcb_vld,
  output logic               tcb_rdy,
  input  logic               tcb_wen,
  input  logic [ADR-1:0]     tcb_adr,
  input  logic [DAT/8-1:0]   tcb_ben,
  input  logic [DAT-1:0]     tcb_wdt,
  output logic [DAT-1:0]     tcb_rdt,
  output logic               tcb_sts
);

  localparam int unsigned BYT = DAT / 8;
  localparam int unsigned AW  = $clog2(SIZ);
  localparam int unsigned BW  = $clog2(BYT);
  localparam int unsigned WRD = SIZ / BYT;

  logic                 hs;
  logic [AW-BW-1:0]     idx;
  logic                 oor;
  logic [DAT-1:0]       rsp_rdt;

  logic [DAT-1:0]       mem [WRD];

  logic [DLY-1:0]       vld_q;
  logic [DLY-1:0]       sts_q;
  logic [DAT-1:0]       rdt_q [DLY];

  logic                 unused_sink;

  assign hs  = tcb_vld & tcb_rdy;
  assign idx = tcb_adr[AW-1:BW];

`ifdef TCB_LIB_MEMORY_ERR_EN
  assign oor = |(tcb_adr >> AW);
`else
  assign oor = 1'b0;
`endif

  assign unused_sink = ^{tcb_adr, vld_q[DLY-1]};

  // Storage is deliberately unreset so it survives a reset pulse.
  always_ff @(posedge clk) begin
    if (hs && tcb_wen && !oor) begin
      for (int i = 0; i < BYT; i++) begin
        if (tcb_ben[i]) begin
          mem[idx][8*i +: 8] <= tcb_wdt[8*i +: 8];
        end
      end
    end
  end

  assign rsp_rdt = (tcb_wen || oor) ? '0 : mem[idx];

  // Each stage only captures data when a valid response enters it, so the
  // last stage doubles as the holding output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcb_rdy <= 1'b0;
      vld_q   <= '0;
      sts_q   <= '0;
      for (int k = 0; k < DLY; k++) begin
        rdt_q[k] <= '0;
      end
    end else begin
      tcb_rdy  <= 1'b1;
      vld_q[0] <= hs;
      if (hs) begin
        rdt_q[0] <= rsp_rdt;
        sts_q[0] <= oor;
      end
      for (int k = 1; k < DLY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          rdt_q[k] <= rdt_q[k-1];
          sts_q[k] <= sts_q[k-1];
        end
      end
    end
  end

  assign tcb_rdt = rdt_q[DLY-1];
  assign tcb_sts = sts_q[DLY-1];

endmodule

// File: doc/tcb_lib_memory.md
# tcb_lib_memory

TCB subordinate responder: a byte-addressed, byte-enable-capable RAM that accepts TCB requests every cycle and returns read data and status a fixed `DLY` cycles after each handshake. It is the far (subordinate) end of any TCB manager or library stage and serves as the synthesizable reference responder for library benches and small on-chip memories.

## Interface
- `ADR`, 32, address width (byte address)
- `DAT`, 32, data width; multiple of 8; `BYT = DAT/8` byte lanes
- `SIZ`, 4096, memory size in bytes; power of two, ≥ `BYT`
- `DLY`, 1, response delay in cycles; legal range 1..4

- `clk`  in  1  clock, all flops on rising edge
- `rst`  in  1  reset, asynchronous assert, active-low, release synchronous to `clk` externally
- `tcb_vld`  in  1  request valid
- `tcb_rdy`  out  1  request ready
- `tcb_wen`  in  1  1 = write, 0 = read
- `tcb_adr`  in  ADR  byte address
- `tcb_ben`  in  BYT  byte enables
- `tcb_wdt`  in  DAT  write data, lane i = bits 8i+7:8i
- `tcb_rdt`  out  DAT  read data
- `tcb_sts`  out  1  status, 0 = OK, 1 = error

## Operation
- Handshake: transfer occurs in cycle where `tcb_vld & tcb_rdy`; no other cycle has effect.
- `tcb_rdy` is a flop: 0 during reset, 1 from first clock edge after `rst` deasserts, then constant 1 (no back-pressure).
- Word index = `tcb_adr[log2(SIZ)-1 : log2(BYT)]`; address bits below `log2(BYT)` ignored (aligned access only).
- Write: at the handshake edge each lane with `tcb_ben[i]=1` stores `tcb_wdt` lane i; lanes with `ben=0` unchanged. Response rdt = 0.
- Read: word fetched at the handshake edge into pipeline stage 1; `tcb_ben` ignored, all lanes returned.
- Response pipeline: `DLY` stages, each `{vld, rdt, sts}`; stage 1 loaded on handshake, stage k from k-1 each cycle.
- Output register updates only when last stage `vld=1`; otherwise holds previous `tcb_rdt`/`tcb_sts` (hold behaviour).
- Memory array is not reset; contents unknown until written; reset does not clear it.
- Reset mid-operation: all pipeline `vld` cleared, in-flight responses dropped, outputs forced to reset values; memory retains contents.

## Timing
- Reset values: `tcb_rdy=0`, `tcb_rdt=0`, `tcb_sts=0`, all pipeline `vld=0`.
- Latency: handshake in cycle N → response valid on `tcb_rdt`/`tcb_sts` in cycle N+`DLY`, held until next response.
- Throughput: one transfer per cycle, back-to-back responses in consecutive cycles.
- Write at N, read same word at N+1: read returns newly written data (write lands at end of N).
- Multiple writes to same word in consecutive cycles: last write wins per lane.

## Configuration
- `TCB_LIB_MEMORY_ERR_EN` defined: address with any bit at or above `log2(SIZ)` set is out of range → write suppressed, read returns rdt 0, `tcb_sts=1` at N+`DLY`; in-range accesses `sts=0`.
- Undefined: upper address bits ignored, address wraps modulo `SIZ`, `tcb_sts` always 0.

## Test plan
- Reset: hold `rst=0` 2 cycles → `tcb_rdy=0`, `tcb_rdt=0`, `tcb_sts=0`; release → `tcb_rdy=1` next edge.
- Write/read, DLY=1: write `adr=0x10, ben=0xF, wdt=0x76543210` at N, read 0x10 at N+1 → `rdt=0x76543210, sts=0` at N+2, held through idle cycles.
- Byte enables: after above, write `adr=0x10, ben=0x5, wdt=0xAABBCCDD`, read 0x10 → `rdt=0x76BB32DD`.
- Back-to-back, DLY=3: reads of 0x0,0x4,0x8 (preloaded 1,2,3) in cycles N..N+2 → rdt 1,2,3 in cycles N+3..N+5.
- Out of range, SIZ=4096: with `TCB_LIB_MEMORY_ERR_EN` write then read `adr=0x1000` → `sts=1, rdt=0`, word 0 unchanged; without macro read returns value written, aliasing word 0, `sts=0`.
- Reset mid-flight, DLY=2: read at N, `rst=0` in N+1 → no response at N+2, outputs 0; data written before reset still readable after release.
